// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through D-cache: one LSQ read/write/flush in flight, full-line burst fill on miss.
// Latency: read hit 1 cycle; miss/write wait on mem_ack_IN (+ fill beats); flush LINES+1 cycles. Optional DCACHE_STATS_EN.
// Backpressure: requests sampled only when idle; mem_req_OUT held until mem_ack_IN; fill beats accepted whenever they arrive.
module dcache_ctrl #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic        MemFlush_IN,
    input  logic [31:0] data_address_IN,
    input  logic [31:0] data_write_IN,
    input  logic [3:0]  byte_en_IN,
    output logic [31:0] data_read_OUT,
    output logic        data_valid_OUT,
    output logic        busy_OUT,
    output logic        mem_req_OUT,
    output logic        mem_we_OUT,
    output logic [31:0] mem_addr_OUT,
    output logic [31:0] mem_wdata_OUT,
    output logic [3:0]  mem_be_OUT,
    input  logic        mem_ack_IN,
    input  logic [31:0] mem_rdata_IN,
    input  logic        mem_rvalid_IN
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count_OUT,
    output logic [31:0] miss_count_OUT
`endif
);

    localparam int BW   = $clog2(WORDS_PER_LINE);
    localparam int IDXW = $clog2(LINES);
    localparam int OFF  = 2 + BW;
    localparam int TAGW = 32 - OFF - IDXW;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL_REQ, S_FILL_DATA, S_WRITE, S_FLUSH, S_RESP
    } state_t;

    state_t state, next_state;

    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
    logic [TAGW-1:0]  tag_mem  [LINES];
    logic [LINES-1:0] valid_q;

    logic [31:0]     req_addr, req_wdata, rd_data;
    logic [3:0]      req_be;
    logic [BW-1:0]   beat_cnt;
    logic [IDXW-1:0] flush_cnt;

    logic [IDXW-1:0] in_idx, req_idx;
    logic [TAGW-1:0] in_tag, req_tag;
    logic [BW-1:0]   in_off, req_off;
    logic            lookup_hit, accept_read, accept_write, accept_flush;
    logic            fill_beat, last_beat;
    logic [31:0]     hit_word, merged_word;
    logic            unused_addr_lsbs;

    assign in_idx  = data_address_IN[OFF+IDXW-1:OFF];
    assign in_tag  = data_address_IN[31:OFF+IDXW];
    assign in_off  = data_address_IN[OFF-1:2];
    assign req_idx = req_addr[OFF+IDXW-1:OFF];
    assign req_tag = req_addr[31:OFF+IDXW];
    assign req_off = req_addr[OFF-1:2];
    assign unused_addr_lsbs = ^data_address_IN[1:0];

    assign lookup_hit   = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
    assign accept_flush = (state == S_IDLE) && MemFlush_IN;
    assign accept_write = (state == S_IDLE) && !MemFlush_IN && MemWrite_IN;
    assign accept_read  = (state == S_IDLE) && !MemFlush_IN && !MemWrite_IN && MemRead_IN;
    assign fill_beat    = (state == S_FILL_DATA) && mem_rvalid_IN;
    assign last_beat    = fill_beat && (beat_cnt == '1);
    assign hit_word     = data_mem[{in_idx, in_off}];

    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en_IN[b]) merged_word[8*b +: 8] = data_write_IN[8*b +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (MemFlush_IN)      next_state = S_FLUSH;
                else if (MemWrite_IN) next_state = S_WRITE;
                else if (MemRead_IN)  next_state = lookup_hit ? S_RESP : S_FILL_REQ;
            end
            S_FILL_REQ:  if (mem_ack_IN) next_state = S_FILL_DATA;
            S_FILL_DATA: if (last_beat) next_state = S_RESP;
            S_WRITE:     if (mem_ack_IN) next_state = S_RESP;
            S_FLUSH:     if (flush_cnt == '1) next_state = S_RESP;
            S_RESP:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        data_valid_OUT = (state == S_RESP);
        busy_OUT       = (state != S_IDLE);
        mem_req_OUT    = 1'b0;
        mem_we_OUT     = 1'b0;
        mem_addr_OUT   = '0;
        mem_wdata_OUT  = '0;
        mem_be_OUT     = '0;
        case (state)
            S_FILL_REQ: begin
                mem_req_OUT  = 1'b1;
                mem_addr_OUT = {req_addr[31:OFF], {OFF{1'b0}}};
            end
            S_WRITE: begin
                mem_req_OUT   = 1'b1;
                mem_we_OUT    = 1'b1;
                mem_addr_OUT  = req_addr;
                mem_wdata_OUT = req_wdata;
                mem_be_OUT    = req_be;
            end
            default: ;
        endcase
    end

    assign data_read_OUT = rd_data;

    // Valid is set only on the final beat, so an abandoned fill never leaves a usable line.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            rd_data   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else begin
            if (accept_read || accept_write) begin
                req_addr  <= {data_address_IN[31:2], 2'b00};
                req_wdata <= data_write_IN;
                req_be    <= byte_en_IN;
            end
            if (accept_read && lookup_hit) rd_data <= hit_word;
            if (fill_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == req_off) rd_data <= mem_rdata_IN;
                if (last_beat) valid_q[req_idx] <= 1'b1;
            end
            if (state == S_FLUSH) begin
                valid_q[flush_cnt] <= 1'b0;
                flush_cnt          <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept_write && lookup_hit) data_mem[{in_idx, in_off}] <= merged_word;
        if (fill_beat) data_mem[{req_idx, beat_cnt}] <= mem_rdata_IN;
        if (last_beat) tag_mem[req_idx] <= req_tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept_read) begin
            if (lookup_hit) hit_cnt  <= hit_cnt + 1'b1;
            else            miss_cnt <= miss_cnt + 1'b1;
        end
    end

    assign hit_count_OUT  = hit_cnt;
    assign miss_count_OUT = miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked against a memory-plus-residency model.
module tb_dcache_ctrl;

    localparam int LINES = 64;
    localparam int WPL   = 4;
    localparam int OFF   = 4;
    localparam int IDXW  = 6;

    logic        CLK, RESET;
    logic        MemRead_IN, MemWrite_IN, MemFlush_IN;
    logic [31:0] data_address_IN, data_write_IN;
    logic [3:0]  byte_en_IN;
    logic [31:0] data_read_OUT;
    logic        data_valid_OUT, busy_OUT, mem_req_OUT, mem_we_OUT;
    logic [31:0] mem_addr_OUT, mem_wdata_OUT;
    logic [3:0]  mem_be_OUT;
    logic        mem_ack_IN, mem_rvalid_IN;
    logic [31:0] mem_rdata_IN;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_OUT, miss_count_OUT;
`endif

    dcache_ctrl #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .CLK(CLK), .RESET(RESET),
        .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .MemFlush_IN(MemFlush_IN),
        .data_address_IN(data_address_IN), .data_write_IN(data_write_IN), .byte_en_IN(byte_en_IN),
        .data_read_OUT(data_read_OUT), .data_valid_OUT(data_valid_OUT), .busy_OUT(busy_OUT),
        .mem_req_OUT(mem_req_OUT), .mem_we_OUT(mem_we_OUT), .mem_addr_OUT(mem_addr_OUT),
        .mem_wdata_OUT(mem_wdata_OUT), .mem_be_OUT(mem_be_OUT),
        .mem_ack_IN(mem_ack_IN), .mem_rdata_IN(mem_rdata_IN), .mem_rvalid_IN(mem_rvalid_IN)
`ifdef DCACHE_STATS_EN
        , .hit_count_OUT(hit_count_OUT), .miss_count_OUT(miss_count_OUT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: backing memory plus which tag each index holds.
    logic [31:0] mem_model [int unsigned];
    bit          mvalid [LINES];
    int unsigned mtag   [LINES];
    int unsigned m_hits = 0, m_misses = 0;

    logic [31:0] rd;
    bit          f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a >> 2)) return mem_model[a >> 2];
        return {a[31:2], 2'b00} ^ 32'h5EED_0000;
    endfunction

    task automatic clear_inputs();
        MemRead_IN = 0; MemWrite_IN = 0; MemFlush_IN = 0;
        mem_ack_IN = 0; mem_rvalid_IN = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) mvalid[i] = 0;
        m_hits = 0; m_misses = 0;
    endtask

    // op: 0 read, 1 write, 2 flush. noise adds lower-priority request bits.
    task automatic access(input int op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input bit noise,
                          output logic [31:0] rdata, output bit filled);
        int          idx     = int'(addr[OFF+IDXW-1:OFF]);
        int unsigned tg      = addr[31:OFF+IDXW];
        bit          exp_hit = mvalid[idx] && (mtag[idx] == tg);
        logic [31:0] exp_dat = mem_rd(addr);
        logic [31:0] line    = {addr[31:OFF], 4'h0};
        logic [31:0] cur;
        int          cycles = 0, beats = 0;
        bit          acked = 0, done = 0, saw_req = 0;
        rdata = '0; filled = 0;
        if (op == 0) begin
            if (exp_hit) m_hits++;
            else begin m_misses++; mvalid[idx] = 1; mtag[idx] = tg; end
        end else if (op == 1) begin
            cur = mem_rd(addr);
            for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
            mem_model[addr >> 2] = cur;
        end else begin
            for (int i = 0; i < LINES; i++) mvalid[i] = 0;
        end
        MemFlush_IN = (op == 2);
        MemWrite_IN = (op == 1) || (op == 2 && noise && $urandom_range(0, 1) == 1);
        MemRead_IN  = (op == 0) || (op != 0 && noise && $urandom_range(0, 1) == 1);
        data_address_IN = addr; data_write_IN = wd; byte_en_IN = be;
        while (!done && cycles < 300) begin
            @(negedge CLK);
            cycles++;
            mem_ack_IN = 0; mem_rvalid_IN = 0; mem_rdata_IN = $urandom;
            if (data_valid_OUT) begin
                done = 1;
                rdata = data_read_OUT;
                clear_inputs();
            end else if (mem_req_OUT) begin
                saw_req = 1;
                check("mem_we", mem_we_OUT, op == 1);
                check("mem_addr", mem_addr_OUT, (op == 1) ? {addr[31:2], 2'b00} : line);
                if (op == 1) begin
                    check("mem_wdata", mem_wdata_OUT, wd);
                    check("mem_be", mem_be_OUT, be);
                end
                if ($urandom_range(0, 1) == 1) begin mem_ack_IN = 1; acked = 1; end
                else mem_rvalid_IN = 1;
            end else if (acked && op == 0 && beats < WPL && $urandom_range(0, 2) != 0) begin
                mem_rvalid_IN = 1;
                mem_rdata_IN  = mem_rd(line + 32'(beats * 4));
                beats++;
            end
        end
        check("completion_timeout", done, 1);
        if (done) begin
            filled = saw_req && (op == 0);
            check("mem_req_seen", saw_req, (op == 1) || (op == 0 && !exp_hit));
            if (op == 0) begin
                check("read_data", rdata, exp_dat);
                if (exp_hit) check("hit_latency", cycles, 1);
                else         check("fill_beats", beats, WPL);
            end
            if (op == 2) check("flush_latency", cycles, LINES + 1);
            @(negedge CLK);
            check("valid_single_pulse", data_valid_OUT, 0);
            check("busy_after_resp", busy_OUT, 0);
        end else begin
            clear_inputs();
        end
    endtask

    initial begin
        int r;
        logic [31:0] a;
        RESET = 0;
        clear_inputs();
        data_address_IN = 0; data_write_IN = 0; byte_en_IN = 0; mem_rdata_IN = 0;
        model_reset();
        mem_model[32'h100 >> 2] = 32'hA0; mem_model[32'h104 >> 2] = 32'hA1;
        mem_model[32'h108 >> 2] = 32'hA2; mem_model[32'h10C >> 2] = 32'hA3;

        repeat (2) @(negedge CLK);
        check("rst_data_read", data_read_OUT, 0);
        check("rst_data_valid", data_valid_OUT, 0);
        check("rst_busy", busy_OUT, 0);
        check("rst_mem_req", mem_req_OUT, 0);
        check("rst_mem_we", mem_we_OUT, 0);
        check("rst_mem_addr", mem_addr_OUT, 0);
        check("rst_mem_wdata", mem_wdata_OUT, 0);
        check("rst_mem_be", mem_be_OUT, 0);
        RESET = 1;
        @(negedge CLK);

        access(0, 32'h100, 0, 0, 0, rd, f);
        check("t1_data", rd, 32'hA0);  check("t1_fill", f, 1);
        access(0, 32'h108, 0, 0, 0, rd, f);
        check("t2_data", rd, 32'hA2);  check("t2_fill", f, 0);
`ifdef DCACHE_STATS_EN
        check("t2_hit_count", hit_count_OUT, 1);
        check("t2_miss_count", miss_count_OUT, 1);
`endif
        access(1, 32'h104, 32'hDEADBEEF, 4'b1100, 0, rd, f);
        access(0, 32'h104, 0, 0, 0, rd, f);
        check("t3_merged", rd, 32'hDEAD00A1);  check("t3_fill", f, 0);

        access(1, 32'h2000, 32'h11223344, 4'b1111, 0, rd, f);
        access(0, 32'h2000, 0, 0, 0, rd, f);
        check("t4_nowa_fill", f, 1);  check("t4_nowa_data", rd, 32'h11223344);
        access(0, 32'h500, 0, 0, 0, rd, f);  check("t4_alias_fill", f, 1);
        access(0, 32'h100, 0, 0, 0, rd, f);  check("t4_evicted_fill", f, 1);

        access(0, 32'h10C, 0, 0, 0, rd, f);  check("t5_resident", f, 0);
        access(2, 32'h0, 0, 0, 0, rd, f);
        access(0, 32'h100, 0, 0, 0, rd, f);  check("t5_flushed_fill", f, 1);

        // Abort a fill after two beats.
        access(2, 32'h0, 0, 0, 0, rd, f);
        MemRead_IN = 1; data_address_IN = 32'h100;
        for (int i = 0; i < 5 && !mem_req_OUT; i++) @(negedge CLK);
        check("t6_fill_req", mem_req_OUT, 1);
        mem_ack_IN = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            mem_ack_IN = 0; mem_rvalid_IN = 1; mem_rdata_IN = mem_rd(32'h100 + 32'(i * 4));
        end
        @(negedge CLK);
        mem_rvalid_IN = 0; MemRead_IN = 0; RESET = 0;
        #1;
        check("t6_mem_req", mem_req_OUT, 0);
        check("t6_busy", busy_OUT, 0);
        check("t6_data_valid", data_valid_OUT, 0);
        model_reset();
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
        access(0, 32'h100, 0, 0, 0, rd, f);  check("t6_refill", f, 1);

        // Reset while a write request is outstanding must drop mem_req_OUT at once.
        MemWrite_IN = 1; data_address_IN = 32'h40; data_write_IN = 32'h12345678; byte_en_IN = 4'hF;
        for (int i = 0; i < 5 && !mem_req_OUT; i++) @(negedge CLK);
        check("wr_req_up", mem_req_OUT, 1);
        RESET = 0; MemWrite_IN = 0;
        #1;
        check("async_req_drop", mem_req_OUT, 0);
        model_reset();
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            access((r < 50) ? 0 : (r < 96) ? 1 : 2, a, $urandom, 4'($urandom_range(0, 15)), 1, rd, f);
        end
`ifdef DCACHE_STATS_EN
        check("final_hit_count", hit_count_OUT, m_hits);
        check("final_miss_count", miss_count_OUT, m_misses);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
